chimp_board: RTL

- Board datapath for the chimp memory game.
- Holds a ROWS x COLS grid of 6-bit cell values. 0 means an empty cell.
- Places level numbers into pseudo-random free cells when the control path requests it.
- Turns a player's cursor selection into the one-cycle press-number pulse that the chimp control path consumes. Also serves a read port to the VGA renderer.

---
 rtl/chimp_board.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/chimp_board.sv
// chimp_board -- board datapath for the chimp memory game.
//
// Holds a ROWS x COLS grid of 6-bit cell values, where 0 means empty.
// - On request, places a number into a pseudo-random free cell.
// - Turns a cursor selection into a one-cycle press-number pulse.
// - Serves a registered read port to the VGA renderer.
//
// Ports:
//   clk, iReset         clock, asynchronous active-high reset
//   iClear              pulse: empty the whole board (one cell per cycle)
//   iPlace, iNum        pulse: place iNum into a random free cell
//   iCurX/iCurY,iSelect pulse: player selects the cell under the cursor
//   iRdX/iRdY, oRdNum   renderer read port, 1-cycle latency
//   oPressNum           value of the selected cell for one cycle, else 0
//   oBusy               high while clearing or placing
//   oPlaceDone/oPlaceErr  placement finished / refused (board full)
//   oCount              number of occupied cells
//
// Optional build macro:
//   CHIMP_BOARD_FREERUN_EN -- LFSR advances every cycle instead of only in
//   PICK. Without it, placement is a pure function of SEED and the
//   iPlace/iClear history.
module chimp_board #(
    parameter int          COLS      = 8,
    parameter int          ROWS      = 5,
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_TRIES = 8
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iClear,
    input  logic       iPlace,
    input  logic [5:0] iNum,
    input  logic [2:0] iCurX,
    input  logic [2:0] iCurY,
    input  logic       iSelect,
    input  logic [2:0] iRdX,
    input  logic [2:0] iRdY,
    output logic [5:0] oRdNum,
    output logic [5:0] oPressNum,
    output logic       oBusy,
    output logic       oPlaceDone,
    output logic       oPlaceErr,
    output logic [5:0] oCount
);

    localparam int         CELLS   = ROWS * COLS;
    localparam logic [6:0] CELLS_W = 7'(CELLS);
    localparam logic [7:0] TRIES_W = 8'(MAX_TRIES);

    typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_PICK, S_CHECK, S_SCAN} state_t;

    state_t      state;
    logic [5:0]  cells [CELLS];
    logic [15:0] lfsr;
    logic [5:0]  num_l;
    logic [7:0]  tries;
    logic [5:0]  cand;
    logic [5:0]  ptr;
    logic [5:0]  clr_idx;

    function automatic logic in_grid(input logic [2:0] x, input logic [2:0] y);
        return ({1'b0, x} < 4'(COLS)) && ({1'b0, y} < 4'(ROWS));
    endfunction

    function automatic logic [5:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
        return ({3'b0, y} * 6'(COLS)) + {3'b0, x};
    endfunction

    logic [5:0]  sel_idx, rd_idx, sel_val, rd_val, ptr_start;
    logic        sel_ok, rd_ok, cand_free, scan_free, full, ptr_last, clr_last;
    logic        lfsr_adv;
    logic [15:0] lfsr_next;
    logic [7:0]  tries_next;

    always_comb begin
        sel_idx    = cell_idx(iCurX, iCurY);
        sel_ok     = in_grid(iCurX, iCurY);
        sel_val    = sel_ok ? cells[sel_idx] : '0;
        rd_idx     = cell_idx(iRdX, iRdY);
        rd_ok      = in_grid(iRdX, iRdY);
        rd_val     = rd_ok ? cells[rd_idx] : '0;
        // Probes beyond the grid are misses, never an array access.
        cand_free  = ({1'b0, cand} < CELLS_W) && (cells[cand] == '0);
        scan_free  = (cells[ptr] == '0);
        full       = ({1'b0, oCount} == CELLS_W);
        ptr_start  = 6'({1'b0, cand} % CELLS_W);
        ptr_last   = ({1'b0, ptr} == CELLS_W - 7'd1);
        clr_last   = ({1'b0, clr_idx} == CELLS_W - 7'd1);
        tries_next = tries + 8'd1;
        // Fibonacci LFSR, taps 16,14,13,11, shifting toward the MSB.
        lfsr_next  = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

`ifdef CHIMP_BOARD_FREERUN_EN
    assign lfsr_adv = 1'b1;
`else
    assign lfsr_adv = (state == S_PICK);
`endif

    assign oBusy = (state != S_IDLE);

    always_ff @(posedge clk or posedge iReset) begin
        if (iReset) begin
            state      <= S_IDLE;
            lfsr       <= SEED;
            num_l      <= '0;
            tries      <= '0;
            cand       <= '0;
            ptr        <= '0;
            clr_idx    <= '0;
            oRdNum     <= '0;
            oPressNum  <= '0;
            oPlaceDone <= 1'b0;
            oPlaceErr  <= 1'b0;
            oCount     <= '0;
            for (int i = 0; i < CELLS; i++) cells[i] <= '0;
        end else begin
            oPlaceDone <= 1'b0;
            oPlaceErr  <= 1'b0;
            oPressNum  <= '0;
            // Renderer sees the array every cycle, including mid-clear.
            oRdNum     <= rd_val;
            if (lfsr_adv) lfsr <= lfsr_next;

            // Clear wins from any state and restarts the sweep at cell 0.
            if (iClear) begin
                state   <= S_CLEAR;
                clr_idx <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (iPlace) begin
                            if (full) begin
                                oPlaceErr <= 1'b1;
                            end else if (iNum == '0) begin
                                oPlaceDone <= 1'b1;
                            end else begin
                                num_l <= iNum;
                                tries <= '0;
                                state <= S_PICK;
                            end
                        end else if (iSelect && sel_val != '0) begin
                            oPressNum      <= sel_val;
                            cells[sel_idx] <= '0;
                            oCount         <= oCount - 6'd1;
                        end
                    end
                    S_CLEAR: begin
                        cells[clr_idx] <= '0;
                        if (clr_last) begin
                            oCount <= '0;
                            state  <= S_IDLE;
                        end else begin
                            clr_idx <= clr_idx + 6'd1;
                        end
                    end
                    S_PICK: begin
                        cand  <= lfsr[5:0];
                        state <= S_CHECK;
                    end
                    S_CHECK: begin
                        if (cand_free) begin
                            cells[cand] <= num_l;
                            oCount      <= oCount + 6'd1;
                            oPlaceDone  <= 1'b1;
                            state       <= S_IDLE;
                        end else if (tries_next == TRIES_W) begin
                            // Random probing gave up; walk linearly from the last probe.
                            ptr   <= ptr_start;
                            state <= S_SCAN;
                        end else begin
                            tries <= tries_next;
                            state <= S_PICK;
                        end
                    end
                    S_SCAN: begin
                        // Terminates: IDLE only enters here when a free cell exists.
                        if (scan_free) begin
                            cells[ptr] <= num_l;
                            oCount     <= oCount + 6'd1;
                            oPlaceDone <= 1'b1;
                            state      <= S_IDLE;
                        end else begin
                            ptr <= ptr_last ? 6'd0 : ptr + 6'd1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
